gray_rx_monitor: RTL and testbench
==================================

Name: gray_rx_monitor

Overview:
Consumes the Gray-coded count from the upstream Gray counter and produces its binary value. It passes the input through a synchroniser chain and decodes it to binary. It also classifies every change as a legal step (one bit changed, up or down) or an illegal jump (more than one bit changed), and keeps a saturating error count. It sits directly downstream of the Gray counter, on the receive side of a pointer or position crossing.

Parameters:
DATA_WIDTH, 4, width of the Gray input and the binary output; must be at least 2.
SYNC_STAGES, 2, number of flops in the input synchroniser chain; must be at least 2.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
gray_in  input  DATA_WIDTH  Gray-coded count from the upstream counter.
clear_err  input  1  one-cycle request to clear err_flag and err_count.
bin_out  output  DATA_WIDTH  registered binary decode of the synchronised Gray value.
bin_valid  output  1  one-cycle pulse when a legal single-bit step is decoded.
dir_up  output  1  direction of the last legal step: 1 = +1, 0 = -1 (mod 2^DATA_WIDTH).
err_flag  output  1  sticky flag, set on an illegal jump.
err_count  output  ERR_CNT_W  saturating count of illegal jumps.

Behaviour:
- Reset, applied when reset is high at a clk edge:
  - All synchroniser flops and the previous-sample register go to 0.
  - bin_out=0, bin_valid=0, dir_up=0, err_flag=0, err_count=0.
  - State goes to INIT.
  - Reset has priority over every other input, including clear_err, at any point in operation.
- Synchroniser: gray_in shifts through SYNC_STAGES flops; the last stage is called g_s.
- Decode:
  - b[DATA_WIDTH-1] = g_s[DATA_WIDTH-1].
  - b[i] = b[i+1] XOR g_s[i], for i from DATA_WIDTH-2 down to 0.
  - bin_out is registered every cycle in all states.
  - Latency from gray_in to bin_out: SYNC_STAGES+1 cycles.
- Previous-sample register g_p loads g_s every cycle.
- Change classification uses hd = popcount(g_s XOR g_p):
  - hd = 0: no event.
  - hd = 1: legal step.
  - hd > 1: illegal jump.
- dir_up on a legal step:
  - dir_up = 1 if b equals the previous binary value +1 mod 2^DATA_WIDTH, otherwise 0.
  - Wrap-around is a legal step: binary max to 0 gives dir_up=1; 0 to max gives dir_up=0.
  - dir_up holds its value between steps.
- bin_valid and all error updates are registered in the same cycle as bin_out, so they are aligned with it.
- State machine (states INIT, TRACK, FAULT):
  - INIT:
    - Lasts SYNC_STAGES+1 cycles after reset deasserts, while the synchroniser fills.
    - No classification is done: bin_valid=0 and no errors are raised. This avoids a false error when the reset value differs from gray_in.
    - Moves to TRACK when done.
  - TRACK:
    - Legal step: bin_valid=1 for one cycle and dir_up updates.
    - Illegal jump: bin_valid=0, err_flag goes to 1, err_count increments, and the state moves to FAULT.
  - FAULT:
    - Decode and classification continue as in TRACK: legal steps still pulse bin_valid, and further illegal jumps increment err_count.
    - err_flag stays at 1.
    - clear_err=1 sets err_flag=0 and err_count=0, and the state moves to TRACK.
- clear_err in TRACK: clears err_count only.
- clear_err in the same cycle as an illegal jump:
  - The clear is applied first, then the increment.
  - Result: err_count=1, err_flag=1, state FAULT.
- err_count saturates at 2^ERR_CNT_W-1 and never wraps.
- An illegal jump never asserts bin_valid; bin_out still shows the new decoded value.

Test Plan:
- Up-count with wrap (W=4, S=2). Stimulus: reset, then gray_in 0x0,0x1,0x3,0x2,...,0x8,0x0, one value per cycle. Required: after INIT, bin_out follows 0,1,2,...,15,0 with a 3-cycle lag; bin_valid=1 on every step; dir_up=1, including across the 15 to 0 wrap; err_flag=0.
- Hold and down-count. Stimulus: gray_in held at 0x2 for 5 cycles, then 0x3, then 0x1. Required: bin_valid=0 while held; then bin_out 2, 1 with bin_valid pulses and dir_up=0.
- Illegal jump. Stimulus: gray_in 0x1 to 0x2 (binary 1 to 3, hd=2). Required: bin_out=3, bin_valid=0, err_flag=1, err_count=1. A following legal step 0x2 to 0x6 still pulses bin_valid with bin_out=4.
- Saturation and clear. Stimulus: ERR_CNT_W=2, five illegal jumps. Required: err_count stops at 3. Then clear_err in a quiet cycle: err_count=0, err_flag=0. Then clear_err coincident with a jump: err_count=1, err_flag=1.
- Reset mid-operation. Stimulus: reset while in FAULT with gray_in=0xA held. Required: all outputs 0 in the next cycle; no err_flag after INIT even though gray_in≠0; bin_out=12 after SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/gray_rx_monitor.sv
// Receive-side Gray count monitor: synchronises a Gray count, decodes it to binary,
// and classifies each change as a legal single-bit step or an illegal jump.
module gray_rx_monitor #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  dir_up,
  output logic                  err_flag,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int HD_W = $clog2(DATA_WIDTH + 1);
  localparam int IC_W = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] g_s, g_p, b;
  logic [HD_W-1:0]       hd;
  logic [1:0]            state, state_n;
  logic [IC_W-1:0]       init_cnt, init_cnt_n;
  logic                  legal, illegal, dir_n, flag_n;
  logic [ERR_CNT_W-1:0]  cnt_n;

  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    r[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic logic [HD_W-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + HD_W'(v[i]);
    return c;
  endfunction

  assign g_s = sync_q[SYNC_STAGES-1];
  assign b   = gray2bin(g_s);
  assign hd  = popcnt(g_s ^ g_p);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      g_p    <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      g_p <= g_s;
    end
  end

  // Classification is suppressed while the chain fills so a nonzero gray_in
  // out of reset is not mistaken for a jump from the reset value.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    cnt_n      = err_count;
    flag_n     = err_flag;
    legal      = 1'b0;
    illegal    = 1'b0;
    if (state == ST_INIT) begin
      if (init_cnt == IC_W'(SYNC_STAGES)) state_n = ST_TRACK;
      else                                init_cnt_n = init_cnt + IC_W'(1);
    end else begin
      legal   = (hd == HD_W'(1));
      illegal = (hd > HD_W'(1));
    end
    // Clear lands first so a coincident jump still counts as one.
    if (clear_err) begin
      cnt_n  = '0;
      flag_n = 1'b0;
      if (state != ST_INIT) state_n = ST_TRACK;
    end
    if (illegal) begin
      flag_n  = 1'b1;
      state_n = ST_FAULT;
      if (cnt_n != '1) cnt_n = cnt_n + ERR_CNT_W'(1);
    end
    dir_n = legal ? (b == bin_out + DATA_WIDTH'(1)) : dir_up;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir_up    <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      init_cnt  <= init_cnt_n;
      bin_out   <= b;
      bin_valid <= legal;
      dir_up    <= dir_n;
      err_flag  <= flag_n;
      err_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Bench for gray_rx_monitor: directed scenarios plus random steps/jumps/clears/resets,
// checked every cycle against a history-based reference model.
module tb_gray_rx_monitor;

  localparam int W = 4;
  localparam int S = 2;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic         clear_err = 1'b0;
  logic [W-1:0] bin_out, bin_out_s;
  logic         bin_valid, bin_valid_s, dir_up, dir_up_s, err_flag, err_flag_s;
  logic [7:0]   err_count;
  logic [1:0]   err_count_s;

  int checks = 0;
  int errors = 0;

  // model state
  int hist[$];
  int k = 0;
  int e_bin = 0, e_valid = 0, e_dir = 0, e_flag = 0, e_c8 = 0, e_c2 = 0;
  int cur_g = 0;

  always #5 clk = ~clk;

  gray_rx_monitor #(.DATA_WIDTH(W), .SYNC_STAGES(S), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .clear_err(clear_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up),
    .err_flag(err_flag), .err_count(err_count)
  );

  gray_rx_monitor #(.DATA_WIDTH(W), .SYNC_STAGES(S), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .gray_in(gray_in), .clear_err(clear_err),
    .bin_out(bin_out_s), .bin_valid(bin_valid_s), .dir_up(dir_up_s),
    .err_flag(err_flag_s), .err_count(err_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Binary value whose Gray code is g, found by search.
  function automatic int g2b(input int g);
    for (int v = 0; v < M; v++) if ((v ^ (v >> 1)) == g) return v;
    return -1;
  endfunction

  task automatic step(input int g, input bit clr, input bit rst);
    int cur, prev, d;
    gray_in   = g[W-1:0];
    clear_err = clr;
    reset     = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; hist.delete();
      e_bin = 0; e_valid = 0; e_dir = 0; e_flag = 0; e_c8 = 0; e_c2 = 0;
    end else begin
      hist.push_back(g);
      k++;
      cur  = (k > S)     ? hist[k-S-1] : 0;
      prev = (k > S + 1) ? hist[k-S-2] : 0;
      e_bin   = g2b(cur);
      e_valid = 0;
      if (clr) begin e_c8 = 0; e_c2 = 0; e_flag = 0; end
      if (k >= S + 2) begin
        d = $countones(cur ^ prev);
        if (d == 1) begin
          e_valid = 1;
          e_dir = (((g2b(cur) - g2b(prev)) + M) % M == 1) ? 1 : 0;
        end else if (d > 1) begin
          e_flag = 1;
          if (e_c8 < 255) e_c8++;
          if (e_c2 < 3) e_c2++;
        end
      end
    end
    chk("bin_out",     bin_out,     e_bin);
    chk("bin_valid",   bin_valid,   e_valid);
    chk("dir_up",      dir_up,      e_dir);
    chk("err_flag",    err_flag,    e_flag);
    chk("err_count",   err_count,   e_c8);
    chk("bin_out_s",   bin_out_s,   e_bin);
    chk("bin_valid_s", bin_valid_s, e_valid);
    chk("dir_up_s",    dir_up_s,    e_dir);
    chk("err_flag_s",  err_flag_s,  e_flag);
    chk("err_count_s", err_count_s, e_c2);
    cur_g = g;
  endtask

  initial begin
    int r, g, v;
    bit clr, rst;

    // reset, including clear_err alongside it
    step(5, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("rst_bin", bin_out, 0);
    chk("rst_cnt", err_count, 0);

    // up-count 0..15 and wrap to 0
    for (int i = 0; i <= M; i++) begin
      v = i % M;
      step(v ^ (v >> 1), 1'b0, 1'b0);
    end
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    chk("wrap_bin", bin_out, 0);
    chk("wrap_vld", bin_valid, 1);
    chk("wrap_dir", dir_up, 1);
    chk("wrap_flag", err_flag, 0);
    step(0, 1'b0, 1'b0);

    // hold then down-count
    for (int i = 0; i < 5; i++) step(2, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    chk("down_bin", bin_out, 1);
    chk("down_dir", dir_up, 0);
    step(1, 1'b0, 1'b0);

    // illegal jump 0x1 -> 0x2, then legal 0x2 -> 0x6
    step(2, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    chk("jump_bin", bin_out, 3);
    chk("jump_vld", bin_valid, 0);
    chk("jump_flag", err_flag, 1);
    chk("jump_cnt", err_count, 1);
    step(6, 1'b0, 1'b0);
    step(6, 1'b0, 1'b0);
    step(6, 1'b0, 1'b0);
    chk("post_bin", bin_out, 4);
    chk("post_vld", bin_valid, 1);
    step(6, 1'b0, 1'b0);

    // five jumps, saturating the narrow counter
    for (int i = 0; i < 5; i++) step(cur_g ^ 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(cur_g, 1'b0, 1'b0);
    chk("sat_cnt_s", err_count_s, 3);
    chk("sat_cnt", err_count, 6);
    step(cur_g, 1'b1, 1'b0);
    chk("clr_cnt_s", err_count_s, 0);
    chk("clr_flag", err_flag, 0);
    step(cur_g ^ 3, 1'b0, 1'b0);
    step(cur_g, 1'b0, 1'b0);
    step(cur_g, 1'b1, 1'b0);
    chk("clrj_cnt_s", err_count_s, 1);
    chk("clrj_flag", err_flag, 1);

    // reset while in FAULT with 0xA held
    step(10, 1'b0, 1'b0);
    step(10, 1'b1, 1'b1);
    chk("mid_rst_flag", err_flag, 0);
    for (int i = 0; i < S + 1; i++) step(10, 1'b0, 1'b0);
    chk("mid_rst_bin", bin_out, 12);
    chk("mid_rst_noerr", err_flag, 0);
    for (int i = 0; i < 3; i++) step(10, 1'b0, 1'b0);
    chk("mid_rst_noerr2", err_count, 0);

    // random mix
    for (int n = 0; n < 600; n++) begin
      r   = int'($urandom_range(99));
      clr = ($urandom_range(9) == 0);
      rst = 1'b0;
      g   = cur_g;
      if (r < 40) begin
        v = (g2b(cur_g) + 1) % M; g = v ^ (v >> 1);
      end else if (r < 55) begin
        v = (g2b(cur_g) + M - 1) % M; g = v ^ (v >> 1);
      end else if (r < 65) begin
        g = cur_g ^ (1 << $urandom_range(W - 1));
      end else if (r < 82) begin
        g = cur_g;
      end else if (r < 98) begin
        g = int'($urandom_range(M - 1));
      end else begin
        rst = 1'b1;
      end
      step(g, clr, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
